// File: rtl/uart_rx.sv
// uart_rx: UART receiver, the counterpart of uart_tx.
// Frame: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1),
// no parity, idle line high. PIN_RX is synchronized, oversampled by an internal
// tick divider and sampled at mid-bit. The divider and the tick counter
// restart on the start edge so every sample point lines up with the frame.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   PIN_RX     asynchronous serial input line
//   word       last correctly framed word, LSB = first data bit received
//   rx_done    one-cycle pulse, word is valid and updated in this cycle
//   frame_err  one-cycle pulse, stop bit sampled as 0 (word unchanged)
//   busy       high from a validated falling edge until the frame ends
module uart_rx #(
  parameter int IN_CLK_FR  = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PIN_RX,
  output logic [DATA_BITS-1:0] word,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  // Clocks per oversample tick, rounded to the nearest integer.
  localparam int DIV    = (IN_CLK_FR + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx: IN_CLK_FR/(BAUD_RATE*OVERSAMPLE) must round to at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r, state_nx;
  logic                 sync1_r, rx_s, rx_q;
  logic [DIV_W-1:0]     div_cnt_r, div_nx;
  logic [TICK_W-1:0]    tick_cnt_r, tick_nx;
  logic [BIT_W-1:0]     bit_cnt_r, bit_nx;
  logic [DATA_BITS-1:0] shift_r, shift_nx, word_nx;
  logic                 done_nx, ferr_nx, busy_nx;
  logic                 tick_s, fall_s;

  assign tick_s = (div_cnt_r == DIV_LAST);
  // Falling edge needs a 1 on the previous sample, so a held-low line never re-arms.
  assign fall_s = rx_q & ~rx_s;

  // Two-flop synchronizer plus one delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      sync1_r <= PIN_RX;
      rx_s    <= sync1_r;
      rx_q    <= rx_s;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      div_cnt_r  <= {DIV_W{1'b0}};
      tick_cnt_r <= {TICK_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      word       <= {DATA_BITS{1'b0}};
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nx;
      div_cnt_r  <= div_nx;
      tick_cnt_r <= tick_nx;
      bit_cnt_r  <= bit_nx;
      shift_r    <= shift_nx;
      word       <= word_nx;
      rx_done    <= done_nx;
      frame_err  <= ferr_nx;
      busy       <= busy_nx;
    end
  end

  // Next-state and next-value logic for the receive FSM and tick divider.
  always_comb begin
    state_nx = state_r;
    div_nx   = tick_s ? {DIV_W{1'b0}} : (div_cnt_r + 1'b1);
    tick_nx  = tick_cnt_r;
    bit_nx   = bit_cnt_r;
    shift_nx = shift_r;
    word_nx  = word;
    done_nx  = 1'b0;
    ferr_nx  = 1'b0;
    busy_nx  = busy;

    case (state_r)
      IDLE: begin
        busy_nx = 1'b0;
        if (fall_s) begin
          // Restart the divider so ticks are phased to the start edge.
          div_nx   = {DIV_W{1'b0}};
          tick_nx  = {TICK_W{1'b0}};
          busy_nx  = 1'b1;
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end

      START: begin
        if (tick_s) begin
          if (tick_cnt_r == TICK_MID) begin
            if (!rx_s) begin
              tick_nx  = {TICK_W{1'b0}};
              bit_nx   = {BIT_W{1'b0}};
              state_nx = DATA;
            end else begin
              // Line back high at mid start bit: treat as a glitch.
              busy_nx  = 1'b0;
              state_nx = IDLE;
            end
          end else begin
            tick_nx = tick_cnt_r + 1'b1;
          end
        end else begin
          tick_nx = tick_cnt_r;
        end
      end

      DATA: begin
        if (tick_s) begin
          if (tick_cnt_r == TICK_LAST) begin
            tick_nx  = {TICK_W{1'b0}};
            shift_nx = {rx_s, shift_r[DATA_BITS-1:1]};
            bit_nx   = bit_cnt_r + 1'b1;
            if ((bit_cnt_r + 1'b1) == BIT_LAST) begin
              state_nx = STOP;
            end else begin
              state_nx = DATA;
            end
          end else begin
            tick_nx = tick_cnt_r + 1'b1;
          end
        end else begin
          tick_nx = tick_cnt_r;
        end
      end

      STOP: begin
        if (tick_s) begin
          if (tick_cnt_r == TICK_LAST) begin
            // Leave mid-stop-bit so a start bit with no idle gap is still seen.
            tick_nx  = {TICK_W{1'b0}};
            busy_nx  = 1'b0;
            state_nx = IDLE;
            if (rx_s) begin
              word_nx = shift_r;
              done_nx = 1'b1;
            end else begin
              ferr_nx = 1'b1;
            end
          end else begin
            tick_nx = tick_cnt_r + 1'b1;
          end
        end else begin
          tick_nx = tick_cnt_r;
        end
      end

      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. The stimulus drives whole UART frames on
// PIN_RX and pushes the frame-level outcome (good word or framing error with
// the retained word) into a queue; a monitor pops one entry per output pulse.
module tb_uart_rx;

  localparam int BIT_CLK = 160;  // 1.6 MHz / 10 kBd

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       PIN_RX = 1'b1;
  logic [7:0] word;
  logic       rx_done, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int fall_cyc = 0;
  logic prev_pulse = 1'b0;

  typedef struct {
    bit         is_err;
    logic [7:0] w;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_word = 8'h00;

  uart_rx #(
    .IN_CLK_FR (1600000),
    .BAUD_RATE (10000),
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PIN_RX   (PIN_RX),
    .word     (word),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; optionally record the expected outcome first.
  task automatic send_frame(input logic [7:0] d, input int bc, input bit stop_ok,
                            input bit expect_it);
    exp_t e;
    if (expect_it) begin
      if (stop_ok) model_word = d;
      e.is_err = !stop_ok;
      e.w      = model_word;
      exp_q.push_back(e);
    end
    PIN_RX = 1'b0;
    wait_clk(bc);
    for (int i = 0; i < 8; i++) begin
      PIN_RX = d[i];
      wait_clk(bc);
    end
    PIN_RX = stop_ok;
    wait_clk(bc);
  endtask

  // Monitor: every output pulse is matched against the head of the queue.
  always @(negedge clk) begin
    if (rx_done && frame_err) begin
      check("pulse_overlap", 32'd1, 32'd0);
    end
    if ((rx_done || frame_err) && prev_pulse) begin
      check("pulse_back_to_back", 32'd1, 32'd0);
    end
    if (rx_done || frame_err) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rx_done, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, rx_done, frame_err}, e.is_err ? 32'd1 : 32'd2);
        check("word", {24'd0, word}, {24'd0, e.w});
        check("busy_at_pulse", {31'd0, busy}, 32'd0);
      end
    end
    prev_pulse <= rx_done | frame_err;
  end

  initial begin
    logic [7:0] d;
    int         bc;
    bit         ok;

    // Reset state
    wait_clk(4);
    check("rst_word", {24'd0, word}, 32'd0);
    check("rst_done", {31'd0, rx_done}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(20);

    // Single frame 0xA5 with busy timing and latency
    fall_cyc = cyc;
    fork
      send_frame(8'hA5, BIT_CLK, 1'b1, 1'b1);
      begin
        wait_clk(2);
        check("busy_before_edge3", {31'd0, busy}, 32'd0);
        wait_clk(1);
        check("busy_at_edge3", {31'd0, busy}, 32'd1);
        wait_clk(1400);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
      end
    join
    PIN_RX = 1'b1;
    wait_clk(40);
    checks++;
    if ((last_done_cyc - fall_cyc) < 1515 || (last_done_cyc - fall_cyc) > 1530) begin
      errors++;
      $display("FAIL latency actual=%0d required=1515..1530", last_done_cyc - fall_cyc);
    end

    // Back-to-back frames, no idle gap
    send_frame(8'h00, BIT_CLK, 1'b1, 1'b1);
    send_frame(8'hFF, BIT_CLK, 1'b1, 1'b1);
    PIN_RX = 1'b1;
    wait_clk(200);

    // 40-clk glitch: busy rises, then drops at the mid-start check
    PIN_RX = 1'b0;
    wait_clk(3);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_clk(37);
    PIN_RX = 1'b1;
    wait_clk(38);
    check("glitch_busy_still_high", {31'd0, busy}, 32'd1);
    wait_clk(12);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    wait_clk(200);
    send_frame(8'h3C, BIT_CLK, 1'b1, 1'b1);
    wait_clk(100);

    // Bad stop bit followed by a 2000-clk break
    send_frame(8'h3C, BIT_CLK, 1'b0, 1'b1);
    wait_clk(1000);
    check("break_not_busy", {31'd0, busy}, 32'd0);
    wait_clk(1000);
    PIN_RX = 1'b1;
    wait_clk(BIT_CLK);
    send_frame(8'h81, BIT_CLK, 1'b1, 1'b1);
    wait_clk(100);

    // Reset in the middle of data bit 4 of 0xF0
    fork
      send_frame(8'hF0, BIT_CLK, 1'b1, 1'b0);
      begin
        wait_clk(880);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("midrst_word", {24'd0, word}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, rx_done}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err}, 32'd0);
        model_word = 8'h00;
      end
    join
    wait_clk(100);
    send_frame(8'h5A, BIT_CLK, 1'b1, 1'b1);
    wait_clk(100);

    // Baud mismatch
    send_frame(8'hC3, 154, 1'b1, 1'b1);
    wait_clk(100);
    send_frame(8'hC3, 166, 1'b1, 1'b1);
    wait_clk(100);

    // Randomized frames: data, bit period, stop validity and idle gap
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom);
      bc = int'($urandom_range(154, 166));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(d, bc, ok, 1'b1);
      PIN_RX = 1'b1;
      wait_clk(int'($urandom_range(20, 200)));
    end

    wait_clk(200);
    check("all_expected_seen", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
